// File: rtl/exu_wb_buffer_pkg.sv
// Shared constants for the execute-to-writeback buffer: machine width, branch
// polarity, and the packed entry layout {data, rd, wen}.
package exu_wb_buffer_pkg;
  localparam int             XLEN        = 32;
  localparam logic           TAKE_BRANCH = 1'b1;
  localparam logic [XLEN-1:0] ZERO       = '0;

  // Entry layout for the default register index width; wen sits in bit 0.
  localparam int EXWB_RIDX_W   = 5;
  localparam int EXWB_WEN_OFF  = 0;
  localparam int EXWB_RD_OFF   = 1;
  localparam int EXWB_DATA_OFF = EXWB_RD_OFF + EXWB_RIDX_W;
  localparam int EXWB_ENTRY_W  = EXWB_DATA_OFF + XLEN;

  function automatic int exwb_entry_w(input int ridx_w);
    return 1 + ridx_w + XLEN;
  endfunction
endpackage

// File: rtl/exu_wb_fifo.sv
// Generic registered circular FIFO with flush and a registered ready flag.
// EXU_WB_FWD_EN exposes storage, head pointer and count for forwarding.
module exu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ready
`ifdef EXU_WB_FWD_EN
  ,
  output logic [DEPTH-1:0][W-1:0] mem_o,
  output logic [PTR_W-1:0]        rd_ptr_o,
  output logic [CNT_W-1:0]        count_o
`endif
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        count, cnt_nxt;
  logic                    do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (flush)                cnt_nxt = '0;
    else if (do_push && !do_pop) cnt_nxt = count + 1'b1;
    else if (do_pop && !do_push) cnt_nxt = count - 1'b1;
  end

  // ready is registered, so space freed by a pop becomes usable next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= inc(wr_ptr);
        end
        if (do_pop) rd_ptr <= inc(rd_ptr);
      end
      count <= cnt_nxt;
      ready <= (cnt_nxt != CNT_W'(DEPTH));
    end
  end

`ifdef EXU_WB_FWD_EN
  assign mem_o    = mem;
  assign rd_ptr_o = rd_ptr;
  assign count_o  = count;
`endif
endmodule

// File: rtl/exu_wb_buffer.sv
// Execute-to-writeback buffer: formats ALU results into FIFO entries and issues
// a registered fetch redirect for taken branches/jumps. EXU_WB_FWD_EN adds fwd_* outputs.
module exu_wb_buffer
  import exu_wb_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_res,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [RIDX_W-1:0] ex_rd,
  input  logic              ex_rd_wen,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic [XLEN-1:0]   ex_br_target,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [RIDX_W-1:0] wb_rd,
  output logic              wb_wen,
  output logic              redir_valid,
  output logic [XLEN-1:0]   redir_pc
`ifdef EXU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RIDX_W-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);
  localparam int RD_OFF   = 1;
  localparam int DATA_OFF = RD_OFF + RIDX_W;
  localparam int ENTRY_W  = exwb_entry_w(RIDX_W);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic               accept, empty, taken;
  logic [ENTRY_W-1:0] entry, head;
  logic [XLEN-1:0]    e_data;
  logic               e_wen;

  assign accept = ex_valid && ex_ready && !flush;
  assign taken  = ex_is_branch && (ex_alu_res[0] == TAKE_BRANCH);

  // Jumps write the link value; branches and x0 never write
  assign e_data = ex_is_jump ? ex_pc + XLEN'(4) : ex_alu_res;
  assign e_wen  = ex_rd_wen && !ex_is_branch && (ex_rd != '0);
  assign entry  = {e_data, ex_rd, e_wen};

`ifdef EXU_WB_FWD_EN
  logic [DEPTH-1:0][ENTRY_W-1:0] mem;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              count;
`endif

  exu_wb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (accept),
    .pop      (wb_ready),
    .din      (entry),
    .dout     (head),
    .empty    (empty),
    .ready    (ex_ready)
`ifdef EXU_WB_FWD_EN
    ,
    .mem_o    (mem),
    .rd_ptr_o (rd_ptr),
    .count_o  (count)
`endif
  );

  assign wb_valid = !empty;
  assign wb_data  = head[DATA_OFF +: XLEN];
  assign wb_rd    = head[RD_OFF +: RIDX_W];
  assign wb_wen   = head[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_valid <= 1'b0;
      redir_pc    <= ZERO;
    end else begin
      redir_valid <= accept && (taken || ex_is_jump);
      if (accept && ex_is_jump)  redir_pc <= {ex_alu_res[XLEN-1:1], 1'b0};
      else if (accept && taken)  redir_pc <= ex_br_target;
    end
  end

`ifdef EXU_WB_FWD_EN
  // Walk oldest to youngest so the last match is the youngest writer
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PTR_W'((int'(rd_ptr) + i) % DEPTH);
      if (i < int'(count) && mem[idx][0]) begin
        fwd_valid = 1'b1;
        fwd_rd    = mem[idx][RD_OFF +: RIDX_W];
        fwd_data  = mem[idx][DATA_OFF +: XLEN];
      end
    end
    if (flush) fwd_valid = 1'b0;
  end
`endif
endmodule

// File: tb/tb_exu_wb_buffer.sv
// Directed table-driven bench for exu_wb_buffer (DEPTH=2) plus reset sequences.
module tb_exu_wb_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_res, ex_pc, ex_br_target;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen, ex_is_branch, ex_is_jump, flush;
  logic        wb_valid, wb_ready, wb_wen;
  logic [31:0] wb_data, redir_pc;
  logic [4:0]  wb_rd;
  logic        redir_valid;
`ifdef EXU_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  exu_wb_buffer #(.DEPTH(2), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_res(ex_alu_res), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_br_target(ex_br_target), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_wen(wb_wen), .redir_valid(redir_valid), .redir_pc(redir_pc)
`ifdef EXU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic v; logic [31:0] pc, alu; logic [4:0] rd; logic wen, br, j;
    logic [31:0] tgt; logic fl, wbr;
    logic e_wbv; logic [31:0] e_data; logic [4:0] e_rd; logic e_wen, e_rdy, e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic v, logic [31:0] pc, alu, logic [4:0] rd, logic wen,
                              logic br, j, logic [31:0] tgt, logic fl, wbr,
                              logic e_wbv, logic [31:0] e_data, logic [4:0] e_rd,
                              logic e_wen, e_rdy, e_rv, logic [31:0] e_rpc);
    vec_t r;
    r.v = v; r.pc = pc; r.alu = alu; r.rd = rd; r.wen = wen; r.br = br; r.j = j;
    r.tgt = tgt; r.fl = fl; r.wbr = wbr; r.e_wbv = e_wbv; r.e_data = e_data;
    r.e_rd = e_rd; r.e_wen = e_wen; r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rpc = e_rpc;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    ex_valid = r.v; ex_pc = r.pc; ex_alu_res = r.alu; ex_rd = r.rd; ex_rd_wen = r.wen;
    ex_is_branch = r.br; ex_is_jump = r.j; ex_br_target = r.tgt; flush = r.fl;
    wb_ready = r.wbr;
  endtask

  task automatic check_row(input vec_t r, input int row);
    chk("wb_valid", row, 32'(wb_valid), 32'(r.e_wbv));
    if (r.e_wbv) begin
      chk("wb_data", row, wb_data, r.e_data);
      chk("wb_rd", row, 32'(wb_rd), 32'(r.e_rd));
      chk("wb_wen", row, 32'(wb_wen), 32'(r.e_wen));
    end
    chk("ex_ready", row, 32'(ex_ready), 32'(r.e_rdy));
    chk("redir_valid", row, 32'(redir_valid), 32'(r.e_rv));
    chk("redir_pc", row, redir_pc, r.e_rpc);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    //            v pc            alu           rd  wen br j  tgt           fl wbr  wbv data          rd  wen rdy rv rpc
    // back-pressure and in-order drain
    tv.push_back(mk(1,0,           32'h11,       3, 1, 0,0,0,            0,0,  1,32'h11,       3, 1, 1, 0,0));
    tv.push_back(mk(1,0,           32'h22,       4, 1, 0,0,0,            0,0,  1,32'h11,       3, 1, 0, 0,0));
    tv.push_back(mk(1,0,           32'h99,       5, 1, 0,0,0,            0,0,  1,32'h11,       3, 1, 0, 0,0));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  1,32'h22,       4, 1, 1, 0,0));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,0));
    // full, then push while popping: held off one cycle
    tv.push_back(mk(1,0,           32'h44,       6, 1, 0,0,0,            0,0,  1,32'h44,       6, 1, 1, 0,0));
    tv.push_back(mk(1,0,           32'h55,       7, 1, 0,0,0,            0,0,  1,32'h44,       6, 1, 0, 0,0));
    tv.push_back(mk(1,0,           32'h33,       8, 1, 0,0,0,            0,1,  1,32'h55,       7, 1, 1, 0,0));
    tv.push_back(mk(1,0,           32'h33,       8, 1, 0,0,0,            0,0,  1,32'h55,       7, 1, 0, 0,0));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  1,32'h33,       8, 1, 1, 0,0));
    tv.push_back(mk(1,0,           32'h66,       9, 1, 0,0,0,            0,1,  1,32'h66,       9, 1, 1, 0,0));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,0));
    // taken branch, then not-taken branch
    tv.push_back(mk(1,0,           32'h1,       10, 1, 1,0,32'h8000_0100,0,0,  1,32'h1,       10, 0, 1, 1,32'h8000_0100));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,32'h8000_0100));
    tv.push_back(mk(1,0,           32'h0,       10, 1, 1,0,32'h8000_0200,0,1,  1,32'h0,       10, 0, 1, 0,32'h8000_0100));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,32'h8000_0100));
    // jumps: link value, bit-0 cleared target, rd=0, PC wrap
    tv.push_back(mk(1,32'h8000_0000,32'h8000_0203,1, 1, 0,1,0,            0,0,  1,32'h8000_0004,1, 1, 1, 1,32'h8000_0202));
    tv.push_back(mk(1,32'h8000_0010,32'h8000_0301,0, 1, 0,1,0,            0,1,  1,32'h8000_0014,0, 0, 1, 1,32'h8000_0300));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,32'h8000_0300));
    tv.push_back(mk(1,32'hFFFF_FFFC,32'h10,      2, 1, 0,1,0,            0,0,  1,32'h0,        2, 1, 1, 1,32'h10));
    tv.push_back(mk(1,0,           32'h77,       0, 1, 0,0,0,            0,0,  1,32'h0,        2, 1, 0, 0,32'h10));
    // flush at count=2 with push attempt, then flush with an accepted-looking push
    tv.push_back(mk(1,0,           32'h88,      11, 1, 0,0,0,            1,1,  0,0,            0, 0, 1, 0,32'h10));
    tv.push_back(mk(1,0,           32'hAA,      12, 1, 0,0,0,            0,0,  1,32'hAA,      12, 1, 1, 0,32'h10));
    tv.push_back(mk(1,0,           32'hBB,      13, 1, 0,0,0,            1,1,  0,0,            0, 0, 1, 0,32'h10));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,32'h10));
    tv.push_back(mk(1,0,           32'h1,        0, 0, 1,0,32'h1234,     1,0,  0,0,            0, 0, 1, 0,32'h10));
    tv.push_back(mk(1,0,           32'h5A,      15, 0, 0,0,0,            0,0,  1,32'h5A,      15, 0, 1, 0,32'h10));
    tv.push_back(mk(0,0,           0,            0, 0, 0,0,0,            0,1,  0,0,            0, 0, 1, 0,32'h10));

    // reset held two cycles
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", -1, 32'(wb_valid), 0);
    chk("rst_ex_ready", -1, 32'(ex_ready), 1);
    chk("rst_redir_valid", -1, 32'(redir_valid), 0);
    chk("rst_wb_data", -1, wb_data, 0);
    chk("rst_wb_rd", -1, 32'(wb_rd), 0);
    chk("rst_wb_wen", -1, 32'(wb_wen), 0);
    chk("rst_redir_pc", -1, redir_pc, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i]);
`ifdef EXU_WB_FWD_EN
      #1;
      if (tv[i].fl) chk("fwd_valid_flush", i, 32'(fwd_valid), 0);
`endif
      @(posedge clk);
      #1;
      check_row(tv[i], i);
    end

    // reset mid-operation clears data fields and redirect target too
    drive(mk(1,32'h100,32'h201,7,1,0,1,0,0,0, 0,0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("pre_rst_wb_data", 100, wb_data, 32'h104);
    chk("pre_rst_redir_pc", 100, redir_pc, 32'h200);
    drive(mk(1,0,32'hCC,14,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_wb_valid", 101, 32'(wb_valid), 0);
    chk("mid_rst_wb_data", 101, wb_data, 0);
    chk("mid_rst_wb_rd", 101, 32'(wb_rd), 0);
    chk("mid_rst_wb_wen", 101, 32'(wb_wen), 0);
    chk("mid_rst_redir_valid", 101, 32'(redir_valid), 0);
    chk("mid_rst_redir_pc", 101, redir_pc, 0);
    chk("mid_rst_ex_ready", 101, 32'(ex_ready), 1);
    drive(idle);
    @(posedge clk); #1;
    chk("post_rst_wb_valid", 102, 32'(wb_valid), 0);
    chk("post_rst_redir_valid", 102, 32'(redir_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
